pa_ifu_sram_ctrl_1024x37: RTL
=============================

Name: pa_ifu_sram_ctrl_1024x37

Overview:
Access controller that sits directly upstream of the 1024x37 IFU single-port SRAM wrapper and drives its A/CEN/GWEN/D/WEN pins.
- Arbitrates between refill writes and fetch reads.
- Runs a full-array invalidate sweep after reset and on request.
- Returns read data one cycle after grant, holding it stable until the next read.

Parameters:
ADDR_WIDTH, 10, SRAM address width
DATA_WIDTH, 37, SRAM data width
DEPTH, 1024, entries swept by invalidate (2^ADDR_WIDTH)

Ports:
forever_cpuclk  input  1  clock
cpurst_b  input  1  asynchronous active-low reset
inv_req  input  1  pulse: invalidate (zero) entire array
inv_busy  output  1  sweep pending or in progress
wr_req  input  1  write request
wr_addr  input  10  write address
wr_data  input  37  write data
wr_bwen  input  37  per-bit write enable, active high
wr_gnt  output  1  write accepted this cycle
rd_req  input  1  read request
rd_addr  input  10  read address
rd_gnt  output  1  read accepted this cycle
rd_data_vld  output  1  rd_data valid (cycle after rd_gnt)
rd_data  output  37  read data
sram_a  output  10  to SRAM A
sram_cen  output  1  to SRAM CEN, active low
sram_gwen  output  1  to SRAM GWEN, 0 = write
sram_d  output  37  to SRAM D
sram_wen  output  37  to SRAM WEN, per-bit active low
sram_q  input  37  from SRAM Q, valid cycle after read

Behaviour:
- Clock and reset: one clock, forever_cpuclk. cpurst_b is asynchronous, active low.
- Flop reset values:
  - state=IDLE, init_pend=1, cnt=0, rd_data_vld=0, rd_hold=0.
  - While in reset: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0, gnts=0, inv_busy=1.
- FSM states:
  - IDLE to INIT when init_pend=1 or inv_req=1. init_pend clears on entering INIT.
  - INIT to IDLE after the write with cnt=DEPTH-1.
- INIT, one write per cycle:
  - sram_cen=0, sram_gwen=0, sram_a=cnt, sram_d=0, sram_wen=all 0.
  - cnt increments each cycle and wraps to 0 on exit.
  - Sweep takes exactly DEPTH cycles.
- inv_busy = init_pend | (state==INIT). It is registered-state-derived with no combinational path from inv_req.
- inv_req while in INIT is ignored; writes are blocked during the sweep, so the result is equivalent.
- Timing from inv_req:
  - inv_req at IDLE cycle N: addr 0 written at N+1, addr 1023 at N+1024, IDLE at N+1025.
  - inv_busy is high N+1..N+1024.
- Grants, combinational, same cycle, only when state==IDLE and init_pend=0:
  - wr_gnt = wr_req.
  - rd_gnt = rd_req & ~wr_req. Writes have priority; a losing read is held by the requester, not queued here.
  - Requests arriving together with inv_req in IDLE are still granted that cycle; the sweep starts next cycle.
- Granted write drive: sram_a=wr_addr, sram_cen=0, sram_gwen=0, sram_d=wr_data, sram_wen=~wr_bwen. wr_bwen=0 still issues CEN (no-op write).
- Granted read drive: sram_a=rd_addr, sram_cen=0, sram_gwen=1, sram_wen=all 1, sram_d=0.
- No grant: idle levels as in reset.
- Read return:
  - rd_data_vld is registered rd_gnt, so it is high exactly one cycle after grant.
  - rd_data = rd_data_vld ? sram_q : rd_hold.
  - rd_hold captures sram_q when rd_data_vld=1.
  - Back-to-back reads every cycle are supported at full throughput.
- Read-after-write: a read of an address written in the previous cycle returns the new data (SRAM ordering). No bypass needed.
- Reset asserted mid-sweep or mid-read: all flops return to reset values immediately. A new full sweep runs after deassertion, and the in-flight rd_data_vld is dropped.

Test Plan:
- Reset release -> inv_busy=1 for 1025 cycles (one pending cycle plus 1024 sweep cycles). sram_a runs 0..1023 with gwen=0, d=0. No grants during the sweep, even with rd_req/wr_req held high.
- After sweep, write addr 0x155 data 0x1_2345_6789 bwen all 1, then read 0x155 -> rd_gnt; next cycle rd_data_vld=1, rd_data=0x1_2345_6789. rd_data holds that value after vld drops.
- wr_req and rd_req in the same cycle -> wr_gnt=1, rd_gnt=0, sram_gwen=0. Read granted the following cycle.
- Write 0x3FF with data 0x1F_FFFF_FFFF, bwen=0x00_0000_FFFF over zeroed entry -> read returns 0x00_0000_FFFF. sram_wen observed as 0x1F_FFFF_0000.
- inv_req pulse at cycle N in IDLE, plus a second inv_req at N+500 -> sweep ends with IDLE at N+1025, no restart. A prior entry reads 0.
- Assert cpurst_b low at sweep cnt=300 and during a pending read return -> rd_data_vld=0, sram_cen=1 immediately. After release, a full 1024-entry sweep restarts from addr 0.

Source files
------------

// File: rtl/pa_ifu_sram_ctrl_1024x37.sv
// Access controller for the 1024x37 IFU single-port SRAM: write/read arbitration,
// full-array invalidate sweep after reset and on request, and registered read return.
module pa_ifu_sram_ctrl_1024x37 #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 37,
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  inv_req,
  output logic                  inv_busy,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_bwen,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_data_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic {
    IDLE,
    INIT
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic                    init_pend_q, init_pend_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    rd_vld_q;
  logic [DATA_WIDTH-1:0]   rd_hold_q;
  logic                    idle_ok;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= IDLE;
      init_pend_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_pend_q <= init_pend_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_pend_d = init_pend_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (init_pend_q || inv_req) begin
          state_d     = INIT;
          init_pend_d = 1'b0;
        end
      end
      INIT: begin
        // inv_req is ignored here; the running sweep already clears everything.
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idle_ok   = (state_q == IDLE) && !init_pend_q;
    wr_gnt    = idle_ok && wr_req;
    rd_gnt    = idle_ok && rd_req && !wr_req;
    sram_a    = '0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_d    = '0;
    sram_wen  = '1;
    if (state_q == INIT) begin
      sram_a    = cnt_q;
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
    end else if (wr_gnt) begin
      sram_a    = wr_addr;
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_d    = wr_data;
      sram_wen  = ~wr_bwen;
    end else if (rd_gnt) begin
      sram_a    = rd_addr;
      sram_cen  = 1'b0;
    end
  end

  assign inv_busy = init_pend_q | (state_q == INIT);

  // SRAM Q is only valid the cycle after a read, so it is captured for later cycles.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_vld_q  <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      rd_vld_q <= rd_gnt;
      if (rd_vld_q) begin
        rd_hold_q <= sram_q;
      end
    end
  end

  assign rd_data_vld = rd_vld_q;
  assign rd_data     = rd_vld_q ? sram_q : rd_hold_q;

endmodule
